// File: rtl/hci_core_rr_arbiter_pkg.sv
// Shared types and defaults for the hci_core round-robin arbiter slice.
package hci_core_rr_arbiter_pkg;

    localparam int unsigned DEFAULT_DW              = 32;
    localparam int unsigned DEFAULT_BW              = 8;
    localparam int unsigned DEFAULT_AW              = 32;
    localparam int unsigned DEFAULT_UW              = 1;
    localparam int unsigned DEFAULT_MAX_OUTSTANDING = 8;

    // Width of the outstanding counter field in the flags word.
    localparam int unsigned OST_W = $clog2(DEFAULT_MAX_OUTSTANDING) + 1;

    typedef struct packed {
        logic [OST_W-1:0] outstanding;
        logic             full;
        logic             empty;
        logic             err;
    } arb_flags_t;

    // Physical user width: a zero-width user field still needs one wire.
    function automatic int unsigned uw_eff(input int unsigned uw);
        return (uw > 0) ? uw : 1;
    endfunction

    // (a + b) wrapped into 0..n-1, assuming a, b < n.
    function automatic int unsigned wrap_add(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned n);
        int unsigned s;
        s = a + b;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/hci_core_id_fifo.sv
// Flop-based FIFO of requester IDs for in-order response routing.
module hci_core_id_fifo
    import hci_core_rr_arbiter_pkg::*;
#(
    parameter int unsigned IDW   = 2,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [IDW-1:0]             id_i,
    input  logic                       pop_i,
    output logic [IDW-1:0]             id_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [IDW-1:0] mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW:0]    cnt_q, cnt_d;
    logic           do_push, do_pop;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign id_o    = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Next pointers and occupancy; pointers wrap naturally (power-of-2 depth).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer/counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // ID storage; contents are only meaningful while counted.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= id_i;
    end

endmodule

// File: rtl/hci_core_rr_arbiter.sv
// Round-robin arbiter sharing one hci_core master port between NB_REQ requesters,
// with in-order response routing through an outstanding-ID FIFO.
module hci_core_rr_arbiter
    import hci_core_rr_arbiter_pkg::*;
#(
    parameter int unsigned NB_REQ          = 4,
    parameter int unsigned MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
    parameter int unsigned DW              = DEFAULT_DW,
    parameter int unsigned BW              = DEFAULT_BW,
    parameter int unsigned AW              = DEFAULT_AW,
    parameter int unsigned UW              = DEFAULT_UW,
    parameter int unsigned IDW             = $clog2(NB_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    // requester ports
    input  logic [NB_REQ-1:0]        slv_req_i,
    output logic [NB_REQ-1:0]        slv_gnt_o,
    input  logic [AW-1:0]            slv_add_i   [NB_REQ],
    input  logic [NB_REQ-1:0]        slv_wen_i,
    input  logic [DW-1:0]            slv_data_i  [NB_REQ],
    input  logic [DW/BW-1:0]         slv_be_i    [NB_REQ],
    input  logic [uw_eff(UW)-1:0]    slv_user_i  [NB_REQ],
    output logic [NB_REQ-1:0]        slv_r_valid_o,
    output logic [DW-1:0]            slv_r_data_o,
    output logic [uw_eff(UW)-1:0]    slv_r_user_o,
    input  logic [NB_REQ-1:0]        slv_lrdy_i,
    // shared downstream port
    output logic                     mst_req_o,
    input  logic                     mst_gnt_i,
    output logic [AW-1:0]            mst_add_o,
    output logic                     mst_wen_o,
    output logic [DW-1:0]            mst_data_o,
    output logic [DW/BW-1:0]         mst_be_o,
    output logic [DW/BW-1:0]         mst_boffs_o,
    output logic [uw_eff(UW)-1:0]    mst_user_o,
    input  logic                     mst_r_valid_i,
    input  logic [DW-1:0]            mst_r_data_i,
    input  logic [uw_eff(UW)-1:0]    mst_r_user_i,
    output logic                     mst_lrdy_o,
    output arb_flags_t               flags_o
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;

    logic [IDW-1:0] rr_q, rr_d;
    logic           err_q, err_d;
    logic [IDW-1:0] winner;
    logic           any_req;
    logic           handshake;
    logic           id_full, id_empty, id_pop;
    logic [IDW-1:0] head_id;
    logic [CW-1:0]  id_count;

    // Priority scan starting at the rr pointer, wrapping at NB_REQ-1.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        for (int unsigned k = 0; k < NB_REQ; k++) begin
            if (!any_req && slv_req_i[IDW'(wrap_add(int'(rr_q), k, NB_REQ))]) begin
                winner  = IDW'(wrap_add(int'(rr_q), k, NB_REQ));
                any_req = 1'b1;
            end
        end
    end

    assign mst_req_o   = any_req & ~id_full;
    assign handshake   = mst_req_o & mst_gnt_i;
    assign mst_add_o   = slv_add_i[winner];
    assign mst_wen_o   = slv_wen_i[winner];
    assign mst_data_o  = slv_data_i[winner];
    assign mst_be_o    = slv_be_i[winner];
    assign mst_boffs_o = '0;

    if (UW > 0) begin : g_user
        assign mst_user_o   = slv_user_i[winner];
        assign slv_r_user_o = mst_r_user_i;
    end else begin : g_nouser
        assign mst_user_o   = '0;
        assign slv_r_user_o = '0;
    end

    assign slv_r_data_o = mst_r_data_i;

    // Grant and response demux: only the winner sees gnt, only the head ID sees r_valid.
    always_comb begin
        slv_gnt_o     = '0;
        slv_r_valid_o = '0;
        for (int unsigned i = 0; i < NB_REQ; i++) begin
            slv_gnt_o[i]     = handshake & (winner == IDW'(i));
            slv_r_valid_o[i] = mst_r_valid_i & ~id_empty & (head_id == IDW'(i));
        end
    end

    assign mst_lrdy_o = id_empty ? 1'b1 : slv_lrdy_i[head_id];
    assign id_pop     = mst_r_valid_i & mst_lrdy_o & ~id_empty;

    // Pointer advances past the winner only on an accepted transfer; err is sticky.
    always_comb begin
        rr_d  = handshake ? IDW'(wrap_add(int'(winner), 1, NB_REQ)) : rr_q;
        err_d = err_q | (mst_r_valid_i & id_empty);
    end

    // Arbiter state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q  <= '0;
            err_q <= 1'b0;
        end else if (clear_i) begin
            rr_q  <= '0;
            err_q <= 1'b0;
        end else begin
            rr_q  <= rr_d;
            err_q <= err_d;
        end
    end

    hci_core_id_fifo #(
        .IDW   (IDW),
        .DEPTH (MAX_OUTSTANDING)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .push_i  (handshake),
        .id_i    (winner),
        .pop_i   (id_pop),
        .id_o    (head_id),
        .full_o  (id_full),
        .empty_o (id_empty),
        .count_o (id_count)
    );

    assign flags_o.outstanding = OST_W'(id_count);
    assign flags_o.full        = id_full;
    assign flags_o.empty       = id_empty;
    assign flags_o.err         = err_q;

endmodule

// File: tb/tb_hci_core_rr_arbiter.sv
// Directed self-checking bench for hci_core_rr_arbiter (NB_REQ=4, depth 8).
module tb_hci_core_rr_arbiter;
    import hci_core_rr_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst, clr;
    logic [3:0]  s_req, s_gnt, s_wen, s_rv, s_lrdy;
    logic [31:0] s_add  [4];
    logic [31:0] s_data [4];
    logic [3:0]  s_be   [4];
    logic [0:0]  s_user [4];
    logic [31:0] s_rdata;
    logic [0:0]  s_ruser;
    logic        m_req, m_gnt, m_wen, m_rv, m_lrdy;
    logic [31:0] m_add, m_data, m_rdata;
    logic [3:0]  m_be, m_boffs;
    logic [0:0]  m_user, m_ruser;
    arb_flags_t  flags;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hci_core_rr_arbiter #(
        .NB_REQ          (4),
        .MAX_OUTSTANDING (8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .clear_i       (clr),
        .slv_req_i     (s_req),
        .slv_gnt_o     (s_gnt),
        .slv_add_i     (s_add),
        .slv_wen_i     (s_wen),
        .slv_data_i    (s_data),
        .slv_be_i      (s_be),
        .slv_user_i    (s_user),
        .slv_r_valid_o (s_rv),
        .slv_r_data_o  (s_rdata),
        .slv_r_user_o  (s_ruser),
        .slv_lrdy_i    (s_lrdy),
        .mst_req_o     (m_req),
        .mst_gnt_i     (m_gnt),
        .mst_add_o     (m_add),
        .mst_wen_o     (m_wen),
        .mst_data_o    (m_data),
        .mst_be_o      (m_be),
        .mst_boffs_o   (m_boffs),
        .mst_user_o    (m_user),
        .mst_r_valid_i (m_rv),
        .mst_r_data_i  (m_rdata),
        .mst_r_user_i  (m_ruser),
        .mst_lrdy_o    (m_lrdy),
        .flags_o       (flags)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_req   = '0;
        s_wen   = '1;
        s_lrdy  = '1;
        m_gnt   = 1'b0;
        m_rv    = 1'b0;
        m_rdata = '0;
        m_ruser = '0;
        for (int i = 0; i < 4; i++) begin
            s_add[i]  = 32'h1000 + 32'(i) * 32'h10;
            s_data[i] = 32'hA000_0000 + 32'(i);
            s_be[i]   = 4'hF;
            s_user[i] = 1'(i);
        end
    endtask

    task automatic do_clear();
        idle_inputs();
        clr = 1'b1;
        next_cycle();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr = 1'b0;
        idle_inputs();
        next_cycle();
        next_cycle();
        checks++;
        if (s_gnt !== 4'b0 || s_rv !== 4'b0 || m_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: gnt=%b r_valid=%b m_req=%b, want 0000 0000 0", s_gnt, s_rv, m_req);
        end
        checks++;
        if (flags !== {4'd0, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_flags: got %b, want %b", flags, {4'd0, 1'b0, 1'b1, 1'b0});
        end
        rst = 1'b0;
        next_cycle();
        // three grants to port 2, no responses
        s_req = 4'b0100;
        m_gnt = 1'b1;
        repeat (3) next_cycle();
        checks++;
        if (flags.outstanding !== 4'd3) begin
            failures++;
            $display("FAIL reset_pre_count: got %0d, want 3", flags.outstanding);
        end
        // asynchronous reset between edges
        #2;
        rst   = 1'b1;
        s_req = '0;
        m_rv  = 1'b1;
        #1;
        checks++;
        if (flags.outstanding !== 4'd0 || flags.empty !== 1'b1 || s_gnt !== 4'b0 || s_rv !== 4'b0) begin
            failures++;
            $display("FAIL reset_async: count=%0d empty=%b gnt=%b r_valid=%b, want 0 1 0000 0000",
                     flags.outstanding, flags.empty, s_gnt, s_rv);
        end
        next_cycle();
        m_rv = 1'b0;
        rst  = 1'b0;
        next_cycle();
        checks++;
        if (flags.err !== 1'b0) begin
            failures++;
            $display("FAIL reset_err: got %b, want 0", flags.err);
        end
        s_req = 4'b1111;
        m_gnt = 1'b1;
        #1;
        checks++;
        if (s_gnt !== 4'b0001) begin
            failures++;
            $display("FAIL reset_first_grant: got %b, want 0001", s_gnt);
        end
        idle_inputs();
    endtask

    task automatic test_rr_fairness();
        int cnt [4];
        int bad_gnt, bad_rv, bad_cnt, bad_data;
        logic [3:0] exp;
        do_clear();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        bad_gnt = 0; bad_rv = 0; bad_cnt = 0; bad_data = 0;
        s_req = 4'b1111;
        m_gnt = 1'b1;
        for (int k = 0; k < 100; k++) begin
            m_rv    = (k > 0);
            m_rdata = 32'hD000_0000 + 32'(k);
            #1;
            exp = 4'b0001 << (k % 4);
            if (s_gnt !== exp) bad_gnt++;
            if (m_data !== 32'hA000_0000 + 32'(k % 4)) bad_data++;
            for (int i = 0; i < 4; i++) if (s_gnt[i] === 1'b1) cnt[i]++;
            if (k > 0) begin
                if (s_rv !== (4'b0001 << ((k - 1) % 4))) bad_rv++;
                if (flags.outstanding !== 4'd1) bad_cnt++;
            end
            next_cycle();
        end
        checks++;
        if (bad_gnt != 0) begin
            failures++;
            $display("FAIL rr_order: %0d cycles with wrong grant, want 0", bad_gnt);
        end
        checks++;
        if (bad_data != 0) begin
            failures++;
            $display("FAIL rr_mux_data: %0d cycles with wrong mst_data, want 0", bad_data);
        end
        checks++;
        if (cnt[0] != 25 || cnt[1] != 25 || cnt[2] != 25 || cnt[3] != 25) begin
            failures++;
            $display("FAIL rr_share: got %0d/%0d/%0d/%0d, want 25 each", cnt[0], cnt[1], cnt[2], cnt[3]);
        end
        checks++;
        if (bad_rv != 0) begin
            failures++;
            $display("FAIL rr_route: %0d cycles with wrong r_valid, want 0", bad_rv);
        end
        checks++;
        if (bad_cnt != 0) begin
            failures++;
            $display("FAIL rr_push_pop_count: %0d cycles with count!=1, want 0", bad_cnt);
        end
        s_req = '0;
        m_rv  = 1'b1;
        #1;
        checks++;
        if (s_rv !== 4'b1000) begin
            failures++;
            $display("FAIL rr_last_route: got %b, want 1000", s_rv);
        end
        next_cycle();
        m_rv = 1'b0;
        #1;
        checks++;
        if (flags.empty !== 1'b1 || flags.err !== 1'b0) begin
            failures++;
            $display("FAIL rr_drain: empty=%b err=%b, want 1 0", flags.empty, flags.err);
        end
        idle_inputs();
    endtask

    task automatic test_routing();
        do_clear();
        m_gnt    = 1'b1;
        s_req    = 4'b0100;
        s_add[2] = 32'h40;
        #1;
        checks++;
        if (s_gnt !== 4'b0100 || m_add !== 32'h40 || m_wen !== 1'b1) begin
            failures++;
            $display("FAIL route_req2: gnt=%b add=%h wen=%b, want 0100 00000040 1", s_gnt, m_add, m_wen);
        end
        next_cycle();
        s_req    = 4'b0001;
        s_add[0] = 32'h80;
        #1;
        checks++;
        if (s_gnt !== 4'b0001 || m_add !== 32'h80) begin
            failures++;
            $display("FAIL route_req0: gnt=%b add=%h, want 0001 00000080", s_gnt, m_add);
        end
        next_cycle();
        s_req   = '0;
        m_rv    = 1'b1;
        m_rdata = 32'hD0D0_0000;
        #1;
        checks++;
        if (s_rv !== 4'b0100 || s_rdata !== 32'hD0D0_0000) begin
            failures++;
            $display("FAIL route_d0: r_valid=%b data=%h, want 0100 d0d00000", s_rv, s_rdata);
        end
        next_cycle();
        m_rdata = 32'hD1D1_1111;
        #1;
        checks++;
        if (s_rv !== 4'b0001 || s_rdata !== 32'hD1D1_1111) begin
            failures++;
            $display("FAIL route_d1: r_valid=%b data=%h, want 0001 d1d11111", s_rv, s_rdata);
        end
        next_cycle();
        m_rv = 1'b0;
        #1;
        checks++;
        if (flags.empty !== 1'b1 || flags.err !== 1'b0) begin
            failures++;
            $display("FAIL route_empty: empty=%b err=%b, want 1 0", flags.empty, flags.err);
        end
        idle_inputs();
    endtask

    task automatic test_full();
        int grants;
        do_clear();
        grants = 0;
        s_req  = 4'b0010;
        m_gnt  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (s_gnt === 4'b0010) grants++;
            next_cycle();
        end
        checks++;
        if (grants != 8) begin
            failures++;
            $display("FAIL full_grants: got %0d, want 8", grants);
        end
        #1;
        checks++;
        if (s_gnt !== 4'b0 || m_req !== 1'b0 || flags.full !== 1'b1 || flags.outstanding !== 4'd8) begin
            failures++;
            $display("FAIL full_block: gnt=%b req=%b full=%b count=%0d, want 0000 0 1 8",
                     s_gnt, m_req, flags.full, flags.outstanding);
        end
        m_rv = 1'b1;
        #1;
        checks++;
        if (s_rv !== 4'b0010 || m_req !== 1'b0) begin
            failures++;
            $display("FAIL full_pop_cycle: r_valid=%b req=%b, want 0010 0", s_rv, m_req);
        end
        next_cycle();
        m_rv = 1'b0;
        #1;
        checks++;
        if (s_gnt !== 4'b0010 || flags.full !== 1'b0 || flags.outstanding !== 4'd7) begin
            failures++;
            $display("FAIL full_regrant: gnt=%b full=%b count=%0d, want 0010 0 7",
                     s_gnt, flags.full, flags.outstanding);
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        int bad;
        do_clear();
        s_req = 4'b1000;
        m_gnt = 1'b1;
        #1;
        next_cycle();
        s_req     = '0;
        m_gnt     = 1'b0;
        m_rv      = 1'b1;
        s_lrdy[3] = 1'b0;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (m_lrdy !== 1'b0 || s_rv !== 4'b1000 || flags.outstanding !== 4'd1) bad++;
            next_cycle();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_hold: %0d cycles with lrdy/r_valid/count wrong, want 0", bad);
        end
        s_lrdy[3] = 1'b1;
        #1;
        checks++;
        if (m_lrdy !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: lrdy=%b, want 1", m_lrdy);
        end
        next_cycle();
        m_rv = 1'b0;
        #1;
        checks++;
        if (flags.outstanding !== 4'd0 || flags.empty !== 1'b1 || flags.err !== 1'b0) begin
            failures++;
            $display("FAIL bp_pop: count=%0d empty=%b err=%b, want 0 1 0",
                     flags.outstanding, flags.empty, flags.err);
        end
        idle_inputs();
    endtask

    task automatic test_spurious();
        int bad;
        do_clear();
        m_rv = 1'b1;
        #1;
        checks++;
        if (s_rv !== 4'b0 || m_lrdy !== 1'b1 || flags.err !== 1'b0) begin
            failures++;
            $display("FAIL spur_drop: r_valid=%b lrdy=%b err=%b, want 0000 1 0", s_rv, m_lrdy, flags.err);
        end
        next_cycle();
        m_rv = 1'b0;
        bad  = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (flags.err !== 1'b1 || flags.empty !== 1'b1) bad++;
            next_cycle();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL spur_sticky: %0d cycles without err/empty, want 0", bad);
        end
        do_clear();
        #1;
        checks++;
        if (flags.err !== 1'b0) begin
            failures++;
            $display("FAIL spur_clear: err=%b, want 0", flags.err);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_rr_fairness();
        test_routing();
        test_full();
        test_backpressure();
        test_spurious();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
